// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clock divider bank: channel-index width
// and a per-channel state snapshot used for debug visibility.
package clkdiv_pkg;

   // Debug snapshot fields are sized for the widest supported counter.
   localparam int STATE_W = 64;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic [STATE_W-1:0] cnt;
      logic [STATE_W-1:0] div_act;
      logic [STATE_W-1:0] div_pend;
      logic               en_act;
      logic               en_pend;
      logic               pend;
   } chan_state_t;

endpackage

// File: rtl/clock_div_chan.sv
// One divider channel: half-period counter, glitch-free divisor/enable
// changes applied only at half-period boundaries or on sync.
module clock_div_chan
   import clkdiv_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int DEFAULT_DIV = 50,
   parameter bit DEFAULT_EN  = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_we_i,
   input  logic [WIDTH-1:0] cfg_div_i,
   input  logic             cfg_en_i,
   input  logic             sync_i,
   output logic             clk_out_o,
   output logic             tick_o,
   output logic             pend_o,
   output chan_state_t      state_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_act_q, div_act_d;
   logic [WIDTH-1:0] div_pend_q, div_pend_d;
   logic             en_act_q, en_act_d;
   logic             en_pend_q, en_pend_d;
   logic             pend_q, pend_d;
   logic             clk_out_q, clk_out_d;
   logic             tick_q, tick_d;
   logic [WIDTH:0]   cnt_inc;
   logic             boundary;

   // One extra bit so cnt+1 can never wrap past div_act.
   assign cnt_inc  = {1'b0, cnt_q} + (WIDTH+1)'(1);
   assign boundary = en_act_q && (cnt_inc == {1'b0, div_act_q});

   always_comb begin
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      div_pend_d = div_pend_q;
      en_act_d   = en_act_q;
      en_pend_d  = en_pend_q;
      pend_d     = pend_q;
      clk_out_d  = clk_out_q;
      tick_d     = 1'b0;

      if (sync_i) begin
         if (pend_q) begin
            div_act_d = div_pend_q;
            en_act_d  = en_pend_q;
            pend_d    = 1'b0;
         end
         cnt_d     = '0;
         clk_out_d = 1'b0;
         tick_d    = clk_out_q;
      end else if (boundary) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         if (pend_q) begin
            div_act_d = div_pend_q;
            en_act_d  = en_pend_q;
            pend_d    = 1'b0;
            clk_out_d = en_pend_q ? ~clk_out_q : 1'b0;
         end else begin
            clk_out_d = ~clk_out_q;
         end
      end else if (en_act_q) begin
         cnt_d = cnt_inc[WIDTH-1:0];
      end

      // New config is judged against the enable left after sync/boundary.
      if (cfg_we_i) begin
         if (en_act_d) begin
            div_pend_d = cfg_div_i;
            en_pend_d  = cfg_en_i;
            pend_d     = 1'b1;
         end else begin
            div_act_d = cfg_div_i;
            en_act_d  = cfg_en_i;
            cnt_d     = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= '0;
         div_act_q  <= WIDTH'(DEFAULT_DIV);
         div_pend_q <= WIDTH'(DEFAULT_DIV);
         en_act_q   <= DEFAULT_EN;
         en_pend_q  <= DEFAULT_EN;
         pend_q     <= 1'b0;
         clk_out_q  <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_act_q  <= div_act_d;
         div_pend_q <= div_pend_d;
         en_act_q   <= en_act_d;
         en_pend_q  <= en_pend_d;
         pend_q     <= pend_d;
         clk_out_q  <= clk_out_d;
         tick_q     <= tick_d;
      end
   end

   assign clk_out_o = clk_out_q;
   assign tick_o    = tick_q;
   assign pend_o    = pend_q;

   always_comb begin
      state_o          = '0;
      state_o.cnt      = STATE_W'(cnt_q);
      state_o.div_act  = STATE_W'(div_act_q);
      state_o.div_pend = STATE_W'(div_pend_q);
      state_o.en_act   = en_act_q;
      state_o.en_pend  = en_pend_q;
      state_o.pend     = pend_q;
   end

endmodule

// File: rtl/clock_div_bank.sv
// Bank of independent clock dividers sharing one configuration port and a
// global phase-align request. cfg handshake: transfer when cfg_valid && cfg_ready.
module clock_div_bank
   import clkdiv_pkg::*;
#(
   parameter int NCH         = 4,
   parameter int WIDTH       = 32,
   parameter int DEFAULT_DIV = 50,
   parameter bit DEFAULT_EN  = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [ch_w(NCH)-1:0]   cfg_ch,
   input  logic [WIDTH-1:0]       cfg_div,
   input  logic                   cfg_en,
   output logic                   cfg_err,
   input  logic                   sync,
   output logic [NCH-1:0]         clk_out,
   output logic [NCH-1:0]         tick,
   output chan_state_t            dbg_state [NCH]
);

   localparam int CH_W  = ch_w(NCH);
   localparam int NSLOT = 1 << CH_W;

   logic [NCH-1:0]   pend;
   logic [NSLOT-1:0] pend_pad;
   logic             ch_ok;
   logic             hs;
   logic             wr_ok;
   logic             cfg_err_q, cfg_err_d;

   always_comb begin
      pend_pad          = '0;
      pend_pad[NCH-1:0] = pend;
   end

   // Out-of-range channels accept and drop the request so the port never stalls.
   assign ch_ok     = (32'(cfg_ch) < NCH);
   assign cfg_ready = !ch_ok || !pend_pad[cfg_ch];
   assign hs        = cfg_valid && cfg_ready;
   assign wr_ok     = hs && (cfg_div != '0);
   assign cfg_err_d = hs && (cfg_div == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cfg_err_q <= 1'b0;
      else       cfg_err_q <= cfg_err_d;
   end

   assign cfg_err = cfg_err_q;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      clock_div_chan #(
         .WIDTH       (WIDTH),
         .DEFAULT_DIV (DEFAULT_DIV),
         .DEFAULT_EN  (DEFAULT_EN)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .cfg_we_i  (wr_ok && (cfg_ch == CH_W'(i))),
         .cfg_div_i (cfg_div),
         .cfg_en_i  (cfg_en),
         .sync_i    (sync),
         .clk_out_o (clk_out[i]),
         .tick_o    (tick[i]),
         .pend_o    (pend[i]),
         .state_o   (dbg_state[i])
      );
   end

endmodule

// File: tb/tb_clock_div_bank.sv
// Directed bench for clock_div_bank with NCH=4, DEFAULT_DIV=50: idle period
// table, then reconfiguration, stop/restart, error, sync and reset sequences.
module tb_clock_div_bank;
   import clkdiv_pkg::*;

   localparam int NCH   = 4;
   localparam int WIDTH = 32;

   logic             clk       = 1'b0;
   logic             reset     = 1'b1;
   logic             cfg_valid = 1'b0;
   logic [1:0]       cfg_ch    = '0;
   logic [WIDTH-1:0] cfg_div   = '0;
   logic             cfg_en    = 1'b0;
   logic             sync      = 1'b0;
   logic             cfg_ready;
   logic             cfg_err;
   logic [NCH-1:0]   clk_out;
   logic [NCH-1:0]   tick;
   chan_state_t      dbg_state [NCH];

   int n_chk  = 0;
   int n_pass = 0;
   int edge_n = 0;

   typedef struct {
      int       at;
      logic [3:0] exp_clk;
      logic [3:0] exp_tick;
   } vec_t;

   vec_t vecs [7];

   clock_div_bank #(
      .NCH         (NCH),
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (50),
      .DEFAULT_EN  (1'b1)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .cfg_en    (cfg_en),
      .cfg_err   (cfg_err),
      .sync      (sync),
      .clk_out   (clk_out),
      .tick      (tick),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
   endtask

   // Outputs are sampled at the falling edge; edge_n counts rising edges since reset release.
   task automatic adv_to(input int e);
      while (edge_n < e) begin
         @(negedge clk);
         edge_n++;
      end
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic [WIDTH-1:0] div, input logic en);
      cfg_ch    = ch;
      cfg_div   = div;
      cfg_en    = en;
      cfg_valid = 1'b1;
      #1;
      chk("cfg_ready_before_write", cfg_ready, 1);
      @(negedge clk);
      edge_n++;
      cfg_valid = 1'b0;
      #1;
   endtask

   initial begin
      vecs[0] = '{1,   4'h0, 4'h0};
      vecs[1] = '{49,  4'h0, 4'h0};
      vecs[2] = '{50,  4'hF, 4'hF};
      vecs[3] = '{51,  4'hF, 4'h0};
      vecs[4] = '{99,  4'hF, 4'h0};
      vecs[5] = '{100, 4'h0, 4'hF};
      vecs[6] = '{150, 4'hF, 4'hF};

      repeat (3) @(negedge clk);
      chk("reset_clk_out", clk_out, 0);
      chk("reset_tick", tick, 0);
      chk("reset_cfg_err", cfg_err, 0);
      chk("reset_cfg_ready", cfg_ready, 1);
      chk("reset_div_act", dbg_state[2].div_act, 50);
      reset  = 1'b0;
      edge_n = 0;

      // Idle run at default divisor
      foreach (vecs[i]) begin
         adv_to(vecs[i].at);
         chk("idle_clk_out", clk_out, vecs[i].exp_clk);
         chk("idle_tick", tick, vecs[i].exp_tick);
      end

      // ch1 div=3 written mid-period
      adv_to(160);
      cfg_write(2'd1, 3, 1'b1);
      chk("ch1_ready_pending", cfg_ready, 0);
      adv_to(199);
      chk("ch1_ready_before_boundary", cfg_ready, 0);
      chk("clk_out_199", clk_out, 4'hF);
      adv_to(200);
      chk("clk_out_200", clk_out, 4'h0);
      chk("tick_200", tick, 4'hF);
      chk("ch1_ready_after_boundary", cfg_ready, 1);
      adv_to(202);
      chk("ch1_clk_202", clk_out[1], 0);
      adv_to(203);
      chk("clk_out_203", clk_out, 4'b0010);
      chk("tick_203", tick, 4'b0010);
      adv_to(206);
      chk("clk_out_206", clk_out, 4'b0000);
      chk("tick_206", tick, 4'b0010);

      // ch2 stop while low, then restart with div=5
      adv_to(210);
      cfg_write(2'd2, 50, 1'b0);
      adv_to(250);
      chk("clk_out_250", clk_out, 4'b1001);
      chk("tick_250", tick, 4'b1101);
      adv_to(300);
      chk("clk_out_300", clk_out, 4'b0010);
      chk("tick_300", tick, 4'b1001);
      cfg_ch = 2'd2;
      #1;
      chk("ch2_ready_stopped", cfg_ready, 1);
      cfg_write(2'd2, 5, 1'b1);
      chk("ch2_ready_after_start", cfg_ready, 1);
      adv_to(305);
      chk("ch2_clk_305", clk_out[2], 0);
      adv_to(306);
      chk("ch2_clk_306", clk_out[2], 1);
      chk("ch2_tick_306", tick[2], 1);

      // zero divisor rejected on ch0
      adv_to(310);
      chk("cfg_err_idle", cfg_err, 0);
      cfg_write(2'd0, 0, 1'b1);
      chk("cfg_err_pulse", cfg_err, 1);
      chk("ch0_ready_after_err", cfg_ready, 1);
      adv_to(312);
      chk("cfg_err_cleared", cfg_err, 0);
      adv_to(349);
      chk("ch0_clk_349", clk_out[0], 0);
      adv_to(350);
      chk("ch0_clk_350", clk_out[0], 1);
      chk("ch0_tick_350", tick[0], 1);

      // ch0 div=4, ch3 div=7, then sync
      adv_to(360);
      cfg_write(2'd0, 4, 1'b1);
      cfg_write(2'd3, 7, 1'b1);
      cfg_ch = 2'd0;
      #1;
      chk("ch0_ready_pending", cfg_ready, 0);
      adv_to(400);
      chk("clk_out_400_ch0", clk_out[0], 0);
      chk("tick_400_ch3", tick[3], 1);
      adv_to(404);
      chk("ch0_clk_404", clk_out[0], 1);
      adv_to(410);
      sync = 1'b1;
      adv_to(411);
      sync = 1'b0;
      #1;
      chk("sync_clk_out", clk_out, 4'h0);
      chk("sync_tick", tick, 4'b1100);
      chk("sync_ch0_cnt", dbg_state[0].cnt, 0);
      chk("sync_ch3_cnt", dbg_state[3].cnt, 0);
      adv_to(414);
      chk("ch0_clk_414", clk_out[0], 0);
      chk("ch1_clk_414", clk_out[1], 1);
      adv_to(415);
      chk("ch0_clk_415", clk_out[0], 1);
      chk("ch0_tick_415", tick[0], 1);
      adv_to(417);
      chk("ch3_clk_417", clk_out[3], 0);
      adv_to(418);
      chk("ch3_clk_418", clk_out[3], 1);
      chk("ch3_tick_418", tick[3], 1);
      adv_to(419);
      chk("clk_out_419", clk_out, 4'b1100);
      chk("tick_419", tick, 4'b0001);
      chk("ch1_cnt_419", dbg_state[1].cnt, 2);

      // asynchronous reset mid-period
      #1;
      reset = 1'b1;
      #1;
      chk("async_reset_clk_out", clk_out, 0);
      chk("async_reset_tick", tick, 0);
      chk("async_reset_div_act", dbg_state[1].div_act, 50);
      chk("async_reset_pend", dbg_state[0].pend, 0);
      @(negedge clk);
      reset  = 1'b0;
      edge_n = 0;
      adv_to(49);
      chk("post_reset_clk_49", clk_out, 4'h0);
      adv_to(50);
      chk("post_reset_clk_50", clk_out, 4'hF);
      chk("post_reset_tick_50", tick, 4'hF);

      // div=1 toggles every cycle
      cfg_write(2'd1, 1, 1'b1);
      adv_to(100);
      chk("div1_clk_100", clk_out, 4'h0);
      chk("div1_tick_100", tick, 4'hF);
      adv_to(101);
      chk("div1_clk_101", clk_out, 4'b0010);
      chk("div1_tick_101", tick, 4'b0010);
      adv_to(102);
      chk("div1_clk_102", clk_out, 4'b0000);
      chk("div1_tick_102", tick, 4'b0010);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/clock_div_bank.md
CLOCK_DIV_BANK -- requirements
Module: clock_div_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels, 1..16.
REQ-002 Parameter WIDTH, default 32: divisor and counter width in bits.
REQ-003 Parameter DEFAULT_DIV, default 50: reset half-period divisor, in clk cycles, for every channel. 50 gives 1 MHz from 100 MHz.
REQ-004 Parameter DEFAULT_EN, default 1: reset enable state for every channel.
REQ-005 Port clk, input, 1: clock. Reset is reset, asynchronous, active-high. The clock is clk.
REQ-006 Port reset, input, 1: asynchronous active-high reset.
REQ-007 Port cfg_valid, input, 1: configuration request.
REQ-008 Port cfg_ready, output, 1: block can accept a configuration for channel cfg_ch.
REQ-009 Port cfg_ch, input, max(1,$clog2(NCH)): target channel.
REQ-010 Port cfg_div, input, WIDTH: new half-period divisor.
REQ-011 Port cfg_en, input, 1: new channel enable.
REQ-012 Port cfg_err, output, 1: one-cycle pulse marking a rejected configuration.
REQ-013 Port sync, input, 1: single-cycle phase-align request for all channels.
REQ-014 Port clk_out, output, NCH: divided clock per channel, registered.
REQ-015 Port tick, output, NCH: one-cycle strobe per channel, registered.

Function
REQ-016 Each channel SHALL hold:
- cnt (WIDTH)
- div_act, div_pend (WIDTH)
- en_act, en_pend
- pend flag
REQ-017 Running channel (en_act=1): each cycle cnt<=cnt+1. When cnt+1==div_act, a boundary occurs: cnt<=0, clk_out toggles, and tick=1 in that same cycle. The output period is 2*div_act cycles with 50% duty.
REQ-018 Boundary comparison SHALL be done at WIDTH+1 bits, so cnt+1 never wraps. div_act=1 SHALL give clk_out toggling every cycle.
REQ-019 cfg_ready SHALL be combinational and equal to !pend[cfg_ch]. A handshake occurs when cfg_valid && cfg_ready.
REQ-020 On handshake with cfg_div==0: cfg_err=1 next cycle, and no channel state changes.
REQ-021 On handshake with cfg_div!=0 to a running channel: div_pend<=cfg_div, en_pend<=cfg_en, pend<=1.
REQ-022 On handshake with cfg_div!=0 to a stopped channel: div_act<=cfg_div, en_act<=cfg_en, cnt<=0 next cycle. pend stays 0.
REQ-023 At a boundary with pend=1: div_act<=div_pend, en_act<=en_pend, pend<=0. The next half-period uses the new divisor, so no runt pulse occurs.
REQ-024 At a boundary where en_pend=0 is applied: clk_out<=0 instead of toggling, and tick=1. The channel then stops with clk_out=0 and cnt=0. It never produces a high pulse shorter than div_act cycles.
REQ-025 Stopped channel: cnt, clk_out and tick SHALL hold at 0.
REQ-026 Handshake in the same cycle as a boundary of that channel: the boundary uses the old pend state, and the new configuration becomes pending for the next boundary.
REQ-027 sync=1: every channel applies any pending configuration immediately, then sets cnt<=0 and clk_out<=0. tick=1 for channels whose clk_out was 1. sync has priority over boundaries in the same cycle.
REQ-028 Handshake in a sync cycle: sync completes first, then the new configuration is captured per REQ-021/022 against the post-sync en_act.
REQ-029 Channels SHALL be fully independent apart from the shared config port and sync.

Reset
REQ-030 On reset: cnt=0, clk_out=0, tick=0, cfg_err=0, pend=0, div_act=div_pend=DEFAULT_DIV, en_act=en_pend=DEFAULT_EN.
REQ-031 Reset asserted mid-period SHALL abort the period with no completion pulse. Counting restarts from cnt=0 on the first clk edge after deassertion.

Structure
REQ-032 Shared package clkdiv_pkg SHALL hold:
- the channel-index width function
- a channel-state struct typedef (cnt, div_act, div_pend, en_act, en_pend, pend)
REQ-033 One sub-module, clock_div_chan, SHALL implement a single channel. It is instantiated NCH times in a generate loop. The top holds only config decode, cfg_ready mux and cfg_err.

Verification
REQ-034 Reset, DEFAULT_DIV=50, NCH=4 -> all clk_out toggle every 50 cycles in phase; tick pulses every 50 cycles; period 100.
REQ-035 Write ch1 div=3 mid-period -> ch1 finishes the current 50-cycle half-period, then toggles every 3 cycles; cfg_ready for ch1 is low until that boundary.
REQ-036 Write ch2 en=0 while clk_out[2]=0 -> at the next boundary clk_out[2] stays 0, tick[2]=1, then the channel is silent; write en=1 div=5 -> first toggle 5 cycles later.
REQ-037 cfg_div=0 to ch0 -> cfg_err pulses once; ch0 period unchanged.
REQ-038 ch0 div=4, ch3 div=7 running, pulse sync -> both clk_out=0, cnt=0 next cycle; rising edges 4 and 7 cycles later.
REQ-039 Assert reset with ch1 at cnt=2 of div=3 -> clk_out=0 and tick=0 immediately; div_act returns to 50.
